// File: rtl/counter_job_arbiter_if.sv
// Job/counter bundle for counter_job_arbiter: two requester job ports,
// the external up/down counter control/data port and the completion report.
// Signal suffixes (_i/_o) are from the arbiter's point of view.
interface counter_job_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic             req0_dir_i;
  logic [WIDTH-1:0] req0_target_i;
  logic             req1_valid_i;
  logic             req1_ready_o;
  logic             req1_dir_i;
  logic [WIDTH-1:0] req1_target_i;
  logic             cnt_load_o;
  logic [WIDTH-1:0] cnt_load_val_o;
  logic             cnt_en_o;
  logic             cnt_sel_o;
  logic [WIDTH-1:0] cnt_data_i;
  logic             done_valid_o;
  logic             done_id_o;
  logic             done_timeout_o;
  logic             busy_o;

  // Arbiter side
  modport slave (
    input  req0_valid_i, req0_dir_i, req0_target_i,
    input  req1_valid_i, req1_dir_i, req1_target_i,
    input  cnt_data_i,
    output req0_ready_o, req1_ready_o,
    output cnt_load_o, cnt_load_val_o, cnt_en_o, cnt_sel_o,
    output done_valid_o, done_id_o, done_timeout_o, busy_o
  );

  // Requester / counter / environment side
  modport master (
    output req0_valid_i, req0_dir_i, req0_target_i,
    output req1_valid_i, req1_dir_i, req1_target_i,
    output cnt_data_i,
    input  req0_ready_o, req1_ready_o,
    input  cnt_load_o, cnt_load_val_o, cnt_en_o, cnt_sel_o,
    input  done_valid_o, done_id_o, done_timeout_o, busy_o
  );
endinterface

// File: rtl/counter_job_arbiter.sv
// counter_job_arbiter: round-robin arbiter that lends one external up/down
// counter to two requesters. A job preloads the counter (0 for up, all ones
// for down), enables it until the target value appears on the counter
// output, then pulses a completion report (with timeout flag) for one cycle.
module counter_job_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input logic                   clk,
  input logic                   rst,
  counter_job_arbiter_if.slave  bus
);

  localparam int RCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [RCW-1:0]   RUN_LAST = RCW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic             r_id;
  logic             r_dir;
  logic [WIDTH-1:0] r_target;
  logic [RCW-1:0]   r_run_cnt;
  logic             r_timeout;

  logic             w_grant;
  logic             w_accept;
  logic             w_match;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      w_grant = ~r_last_grant;
    end else if (bus.req1_valid_i) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  assign w_accept = (r_state == S_IDLE) && (bus.req0_valid_i || bus.req1_valid_i);
  assign w_match  = (bus.cnt_data_i == r_target);

  // Job sequencing: accept in IDLE, one LOAD cycle, RUN until match/timeout, one DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_dir        <= 1'b0;
      r_target     <= ALL_ZERO;
      r_run_cnt    <= {RCW{1'b0}};
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_dir        <= w_grant ? bus.req1_dir_i : bus.req0_dir_i;
            r_target     <= w_grant ? bus.req1_target_i : bus.req0_target_i;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_run_cnt <= {RCW{1'b0}};
          r_state   <= S_RUN;
        end
        S_RUN: begin
          // a match in the same cycle as the last allowed cycle is not a timeout
          if (w_match) begin
            r_timeout <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_run_cnt == RUN_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_run_cnt <= r_run_cnt + {{(RCW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and counter control decode; enable is combinational on the
  // counter output so the counter stops exactly on the target value
  assign bus.req0_ready_o   = w_accept && !w_grant;
  assign bus.req1_ready_o   = w_accept && w_grant;
  assign bus.cnt_load_o     = (r_state == S_LOAD);
  assign bus.cnt_load_val_o = ((r_state == S_LOAD) && r_dir) ? ALL_ONES : ALL_ZERO;
  assign bus.cnt_en_o       = (r_state == S_RUN) && !w_match;
  assign bus.cnt_sel_o      = r_dir;
  assign bus.done_valid_o   = (r_state == S_DONE);
  assign bus.done_id_o      = (r_state == S_DONE) && r_id;
  assign bus.done_timeout_o = (r_state == S_DONE) && r_timeout;
  assign bus.busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_counter_job_arbiter.sv
// Self-checking bench for counter_job_arbiter. Models the external counter,
// predicts each job's latency/enable count/result from the job parameters,
// and predicts arbitration from a round-robin "last served" variable.
module tb_counter_job_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       frozen;
  logic [3:0] m_cnt;
  logic       m_last;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  counter_job_arbiter_if #(.WIDTH(4)) bus ();

  counter_job_arbiter #(.WIDTH(4), .TIMEOUT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External counter model; "frozen" forces its visible output to 3
  assign bus.cnt_data_i = frozen ? 4'd3 : m_cnt;

  always @(posedge clk) begin
    if (rst) m_cnt <= 4'd0;
    else if (bus.cnt_load_o) m_cnt <= bus.cnt_load_val_o;
    else if (bus.cnt_en_o) m_cnt <= bus.cnt_sel_o ? m_cnt - 4'd1 : m_cnt + 4'd1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (got running, want finished)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit v, input bit dir, input logic [3:0] t);
    if (id == 1'b0) begin
      bus.req0_valid_i = v; bus.req0_dir_i = dir; bus.req0_target_i = t;
    end else begin
      bus.req1_valid_i = v; bus.req1_dir_i = dir; bus.req1_target_i = t;
    end
  endtask

  task automatic drop_valid(input bit id);
    if (id == 1'b0) bus.req0_valid_i = 1'b0;
    else bus.req1_valid_i = 1'b0;
  endtask

  function automatic bit pick(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  // Serve one job for requester id; returns while sampling the DONE cycle
  task automatic serve(input bit id, input bit dir, input logic [3:0] tgt,
                       input bit frz, input bit imm, input bit raise_other);
    int waited, done_k, en_cnt, load_cnt, rdy_busy, busy_bad, sel_bad;
    int steps, exp_lat, exp_en;
    bit got_id, got_to;
    logic rdy, rdy_oth;
    logic [3:0] load_val, end_val;
    steps   = dir ? (15 - int'(tgt)) : int'(tgt);
    exp_lat = 3 + (frz ? 31 : steps);
    exp_en  = frz ? 32 : steps;
    set_req(id, 1'b1, dir, tgt);
    frozen = frz;
    #1;
    waited = 0;
    rdy = id ? bus.req1_ready_o : bus.req0_ready_o;
    while (rdy !== 1'b1 && waited < 50) begin
      tick();
      waited++;
      rdy = id ? bus.req1_ready_o : bus.req0_ready_o;
    end
    rdy_oth = id ? bus.req0_ready_o : bus.req1_ready_o;
    n_vec++;
    if (rdy !== 1'b1) begin
      n_err++;
      $display("FAIL grant_ready: req%0d ready=%b after %0d cycles, want 1", id, rdy, waited);
      drop_valid(id);
      frozen = 1'b0;
      return;
    end
    if (imm) begin
      n_vec++;
      if (waited !== 0) begin
        n_err++;
        $display("FAIL grant_latency: req%0d waited %0d cycles, want 0", id, waited);
      end
    end
    n_vec++;
    if (rdy_oth !== 1'b0) begin
      n_err++;
      $display("FAIL ready_exclusive: other ready=%b, want 0", rdy_oth);
    end
    @(posedge clk);
    #1;
    drop_valid(id);
    m_last = id;
    done_k = 0; en_cnt = 0; load_cnt = 0; rdy_busy = 0; busy_bad = 0; sel_bad = 0;
    got_id = 1'b0; got_to = 1'b0; load_val = 4'd0; end_val = 4'd0;
    for (int k = 1; k <= 60 && done_k == 0; k++) begin
      if (bus.cnt_load_o === 1'b1) begin load_cnt++; load_val = bus.cnt_load_val_o; end
      if (bus.cnt_en_o === 1'b1) en_cnt++;
      if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) rdy_busy++;
      if (bus.busy_o !== 1'b1) busy_bad++;
      if (bus.cnt_sel_o !== dir) sel_bad++;
      if (bus.done_valid_o === 1'b1) begin
        done_k = k; got_id = bus.done_id_o; got_to = bus.done_timeout_o; end_val = bus.cnt_data_i;
      end else begin
        if (raise_other && k == 1) set_req(!id, 1'b1, id ? bus.req0_dir_i : bus.req1_dir_i,
                                           id ? bus.req0_target_i : bus.req1_target_i);
        tick();
      end
    end
    n_vec++;
    if (done_k != exp_lat) begin
      n_err++;
      $display("FAIL done_latency: req%0d dir=%0d tgt=%0d done at A+%0d, want A+%0d",
               id, dir, tgt, done_k, exp_lat);
    end
    n_vec++;
    if (got_id !== id) begin
      n_err++; $display("FAIL done_id: got %0d, want %0d", got_id, id);
    end
    n_vec++;
    if (got_to !== frz) begin
      n_err++; $display("FAIL done_timeout: got %0d, want %0d", got_to, frz);
    end
    n_vec++;
    if (en_cnt != exp_en) begin
      n_err++; $display("FAIL en_cycles: got %0d, want %0d", en_cnt, exp_en);
    end
    n_vec++;
    if (load_cnt != 1 || load_val !== (dir ? 4'hF : 4'h0)) begin
      n_err++;
      $display("FAIL load: %0d strobes val=%h, want 1 strobe val=%h", load_cnt, load_val,
               dir ? 4'hF : 4'h0);
    end
    n_vec++;
    if (rdy_busy != 0 || busy_bad != 0 || sel_bad != 0) begin
      n_err++;
      $display("FAIL busy_phase: ready_hi=%0d busy_lo=%0d sel_bad=%0d, want 0 0 0",
               rdy_busy, busy_bad, sel_bad);
    end
    if (!frz) begin
      n_vec++;
      if (end_val !== tgt) begin
        n_err++; $display("FAIL final_count: got %0d, want %0d", end_val, tgt);
      end
    end
    frozen = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    n_vec++;
    if (bus.done_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.cnt_load_o !== 1'b0 ||
        bus.cnt_en_o !== 1'b0 || bus.cnt_sel_o !== 1'b0 || bus.cnt_load_val_o !== 4'd0 ||
        bus.done_id_o !== 1'b0 || bus.done_timeout_o !== 1'b0 ||
        bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s: dv=%b busy=%b ld=%b en=%b sel=%b lv=%h id=%b to=%b r0=%b r1=%b, want all 0",
               tag, bus.done_valid_o, bus.busy_o, bus.cnt_load_o, bus.cnt_en_o, bus.cnt_sel_o,
               bus.cnt_load_val_o, bus.done_id_o, bus.done_timeout_o,
               bus.req0_ready_o, bus.req1_ready_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 4'd0);
    set_req(1'b1, 1'b0, 1'b0, 4'd0);
    tick(); tick();
    check_idle_zero("reset_outputs");
    rst = 1'b0;
    m_last = 1'b1;
    tick();
  endtask

  task automatic test_single_up();
    serve(1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_tie();
    rst = 1'b1;
    set_req(1'b0, 1'b1, 1'b1, 4'd12);
    set_req(1'b1, 1'b1, 1'b1, 4'd12);
    tick(); tick();
    rst = 1'b0;
    m_last = 1'b1;
    for (int r = 0; r < 2; r++) begin
      set_req(1'b0, 1'b1, 1'b1, 4'd12);
      set_req(1'b1, 1'b1, 1'b1, 4'd12);
      serve(pick(1'b1, 1'b1, m_last), 1'b1, 4'd12, 1'b0, 1'b1, 1'b0);
      tick();
      serve(pick(1'b0, 1'b1, m_last), 1'b1, 4'd12, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic test_target_at_start();
    serve(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_timeout();
    serve(1'b0, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_run();
    int dones;
    set_req(1'b0, 1'b1, 1'b1, 4'd4);
    #1;
    @(posedge clk);
    #1;
    drop_valid(1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_idle_zero("reset_mid_run");
    rst = 1'b0;
    m_last = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done_valid_o === 1'b1) dones++;
      tick();
    end
    n_vec++;
    if (dones != 0) begin
      n_err++; $display("FAIL abort_silent: %0d done pulses, want 0", dones);
    end
    serve(1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_request_while_busy();
    set_req(1'b1, 1'b0, 1'b1, 4'd9);
    serve(1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b1);
    tick();
    set_req(1'b0, 1'b1, 1'b0, 4'd2);
    serve(pick(1'b1, 1'b1, m_last), 1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
    tick();
    serve(1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_random();
    bit v0, v1, w, d, frz;
    logic [3:0] t;
    for (int i = 0; i < 16; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      w = pick(v0, v1, m_last);
      if (w ? v0 : v1) set_req(!w, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      d = 1'($urandom_range(0, 1));
      t = 4'($urandom_range(0, 15));
      frz = (i % 7 == 3);
      if (frz && t == 4'd3) t = 4'd9;
      serve(w, d, t, frz, 1'b1, 1'b0);
      drop_valid(!w);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    frozen = 1'b0;
    m_last = 1'b1;
    bus.req0_valid_i = 1'b0; bus.req0_dir_i = 1'b0; bus.req0_target_i = 4'd0;
    bus.req1_valid_i = 1'b0; bus.req1_dir_i = 1'b0; bus.req1_target_i = 4'd0;
    test_reset();
    test_single_up();
    test_tie();
    test_target_at_start();
    test_timeout();
    test_reset_mid_run();
    test_request_while_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_job_arbiter.md
Name: counter_job_arbiter

Overview:
- Shares one 4-bit up/down counter (clk/sel/data style, registered output) between two requesters.
- Each requester submits a counting job: direction and target value.
- The block arbitrates round-robin, preloads the counter, enables it until the target value appears, and reports completion or timeout.
- Sits between requester logic and the counter instance. The counter itself is external.

Parameters:
- WIDTH, 4, counter data width.
- TIMEOUT, 32, maximum RUN-state cycles before a job is aborted. Must be at least 2^WIDTH + 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid_i  in  1  requester 0 job valid.
- req0_ready_o  out  1  requester 0 job accepted this cycle when valid is also high.
- req0_dir_i  in  1  requester 0 direction: 0 = up, 1 = down.
- req0_target_i  in  WIDTH  requester 0 target count.
- req1_valid_i, req1_ready_o, req1_dir_i, req1_target_i: same as requester 0, for requester 1.
- cnt_load_o  out  1  counter synchronous load strobe.
- cnt_load_val_o  out  WIDTH  counter load value.
- cnt_en_o  out  1  counter count enable.
- cnt_sel_o  out  1  counter direction: 0 = up, 1 = down.
- cnt_data_i  in  WIDTH  counter registered output.
- done_valid_o  out  1  one-cycle completion pulse.
- done_id_o  out  1  requester index of the completed job.
- done_timeout_o  out  1  completed job ended by timeout; qualified by done_valid_o.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie), run_cnt=0.
  - All outputs 0, including cnt_sel_o.
  - Reset during any state aborts the job silently: no done pulse.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - grant = the only valid requester; if both are valid, the one not equal to last_grant.
  - reqX_ready_o = (state==IDLE) && grant==X. This is combinational; at most one ready is high.
  - On handshake: latch id, dir, target; last_grant<=id; next state LOAD.
  - No valid requester: stay in IDLE.
- LOAD, exactly 1 cycle:
  - cnt_load_o=1.
  - cnt_load_val_o = 0 if dir=0, else all ones (2^WIDTH-1).
  - cnt_sel_o = latched dir; it is held through RUN and DONE.
  - Next state RUN; run_cnt<=0.
- RUN:
  - match = (cnt_data_i == latched target).
  - cnt_en_o = !match. This is combinational, so the counter never steps past the target.
  - match: next state DONE, done_timeout<=0.
  - Else if run_cnt==TIMEOUT-1: next state DONE, done_timeout<=1.
  - Else run_cnt<=run_cnt+1.
  - Match takes priority over timeout when both occur in the same cycle.
- DONE, exactly 1 cycle:
  - done_valid_o=1, done_id_o=latched id, done_timeout_o=latched flag.
  - cnt_en_o=0; next state IDLE.
  - No done back-pressure.
- Latency:
  - Accept at cycle A; LOAD at A+1; RUN starts at A+2 with cnt_data_i = start value.
  - Up job with target T: match at A+2+T, done pulse at A+3+T.
  - Down job with target T: done pulse at A+3+(2^WIDTH-1-T).
- Target equal to the start value: match in the first RUN cycle, cnt_en_o stays 0, done at A+3.
- Requests arriving while busy: ready stays low, the request is held by the requester, and it is arbitrated in the next IDLE cycle.
- Back-to-back jobs: minimum spacing is one IDLE cycle between a done pulse and the next accept.
- A requester may drop valid before a handshake with no effect on the block.
- Width rules:
  - All comparisons are unsigned WIDTH-bit.
  - run_cnt width = clog2(TIMEOUT); it never wraps.

Test Plan:
- Reset then req0 {dir=0, target=5} alone -> ready0 high at A; load=1/val=0 at A+1; en high for 5 RUN cycles; done_valid=1, id=0, timeout=0 at A+8; counter holds 5.
- req0 and req1 valid together at reset exit, both {dir=1, target=12} -> req0 served first (done at A+6); req1 accepted in the next IDLE cycle. Repeat the tie -> req0 wins again, since last_grant=1.
- req1 {dir=0, target=0} -> en never asserted; done at A+3 with id=1.
- Bench freezes cnt_data_i at 3 with target=9 -> done_timeout_o=1 after exactly 32 RUN cycles (done at A+34); en high throughout RUN.
- rst asserted for one cycle mid-RUN -> all outputs 0 next cycle, no done pulse; a new req0 afterwards completes normally.
- req1 asserted while a req0 job is busy -> ready1 low until the IDLE cycle after done; then req1 is granted even if req0 is also valid.
